// File: rtl/rvfi_trace_pkg.sv
// Shared types for the RVFI retirement flight recorder: record layout, FSM states, capture modes.
package rvfi_trace_pkg;

  localparam int unsigned REC_TS_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2,
    FROZEN    = 2'd3
  } trace_state_e;

  typedef enum logic [1:0] {
    STREAM = 2'd0,
    STOP   = 2'd1,
    RING   = 2'd2
  } trace_mode_e;

  typedef struct packed {
    logic [REC_TS_W-1:0] ts;
    logic                trig;
    logic [31:0]         pc;
    logic [31:0]         insn;
    logic [4:0]          rd_addr;
    logic [31:0]         rd_wdata;
    logic [31:0]         mem_addr;
  } trace_rec_t;

endpackage

// File: rtl/trace_ring_mem.sv
// Record storage: one synchronous write port, one combinational read port.
// Write lands on the clock edge; read data follows rd_addr with no latency.
module trace_ring_mem
  import rvfi_trace_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  trace_rec_t    wr_data,
  input  logic [AW-1:0] rd_addr,
  output trace_rec_t    rd_data
);

  trace_rec_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rvfi_trace_buffer.sv
// RVFI retirement trace buffer with STREAM/STOP/RING capture and PC-match trigger.
// Capture visible one edge after rvfi_valid; drained over valid/ready at any time, in any state.
module rvfi_trace_buffer
  import rvfi_trace_pkg::*;
#(
  parameter  int unsigned DEPTH  = 16,
  parameter  int unsigned TS_W   = 16,
  parameter  int unsigned POST_W = 8,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              clear_i,
  input  logic [1:0]        mode_i,
  input  logic              trig_en_i,
  input  logic [31:0]       trig_pc_i,
  input  logic [POST_W-1:0] post_trig_i,
  input  logic              rvfi_valid,
  input  logic [31:0]       rvfi_pc_rdata,
  input  logic [31:0]       rvfi_insn,
  input  logic [4:0]        rvfi_rd_addr,
  input  logic [31:0]       rvfi_rd_wdata,
  input  logic [31:0]       rvfi_mem_addr,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output trace_rec_t        out_rec_o,
  output logic [CW-1:0]     count_o,
  output logic [15:0]       drop_cnt_o,
  output logic [1:0]        state_o,
  output logic              frozen_o
);

  trace_state_e      state_q, state_d;
  trace_mode_e       mode;
  logic [TS_W-1:0]   ts_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [15:0]       drop_q;
  logic [POST_W-1:0] post_q, post_d;
  logic              full, pop, capture, wr_en, drop, overwrite, rec_trig;
  trace_rec_t        wr_rec, rd_rec;

  always_comb begin
    unique case (mode_i)
      2'b01:   mode = STOP;
      2'b10:   mode = RING;
      default: mode = STREAM;
    endcase
  end

  assign full    = (count_q == CW'(DEPTH));
  assign pop     = out_valid_o && out_ready_i;
  assign capture = rvfi_valid && (state_q == ARMED || state_q == TRIGGERED);

  // A full buffer with no simultaneous pop loses a record in every mode; RING loses the oldest.
  always_comb begin
    wr_en     = 1'b0;
    drop      = 1'b0;
    overwrite = 1'b0;
    if (capture && !clear_i) begin
      if (full && !pop) begin
        drop = 1'b1;
        if (mode == RING) begin
          wr_en     = 1'b1;
          overwrite = 1'b1;
        end
      end else begin
        wr_en = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (wr_en && !overwrite && !pop) count_d = count_q + 1'b1;
    else if (!wr_en && pop)          count_d = count_q - 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    post_d   = post_q;
    rec_trig = wr_en && (state_q == ARMED) && trig_en_i && (rvfi_pc_rdata == trig_pc_i);
    unique case (state_q)
      IDLE:  state_d = ARMED;
      ARMED: begin
        if (rec_trig) begin
          post_d  = post_trig_i;
          state_d = (post_trig_i == '0) ? FROZEN : TRIGGERED;
        end
      end
      TRIGGERED: begin
        if (wr_en) begin
          post_d = post_q - 1'b1;
          if (post_q == POST_W'(1)) state_d = FROZEN;
        end
      end
      default: ;
    endcase
    // STOP freezes on the capture that fills the buffer, so it never has to drop.
    if (mode == STOP && (drop || (wr_en && count_d == CW'(DEPTH)))) state_d = FROZEN;
    if (!enable_i) state_d = IDLE;
    if (clear_i) begin
      state_d = enable_i ? ARMED : IDLE;
      post_d  = '0;
    end
  end

  always_comb begin
    wr_rec          = '0;
    wr_rec.ts       = REC_TS_W'(ts_q);
    wr_rec.trig     = rec_trig;
    wr_rec.pc       = rvfi_pc_rdata;
    wr_rec.insn     = rvfi_insn;
    wr_rec.rd_addr  = rvfi_rd_addr;
    wr_rec.rd_wdata = rvfi_rd_wdata;
    wr_rec.mem_addr = rvfi_mem_addr;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      post_q   <= '0;
    end else begin
      state_q <= state_d;
      post_q  <= post_d;
      if (enable_i) ts_q <= ts_q + 1'b1;
      if (clear_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        drop_q   <= '0;
      end else begin
        count_q <= count_d;
        if (wr_en)            wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop || overwrite) rd_ptr_q <= rd_ptr_q + 1'b1;
        if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
      end
    end
  end

  trace_ring_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk_i),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_rec),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_rec)
  );

  // Head is masked when empty so stale slots never appear on the port.
  assign out_valid_o = (count_q != '0);
  assign out_rec_o   = out_valid_o ? rd_rec : '0;
  assign count_o     = count_q;
  assign drop_cnt_o  = drop_q;
  assign state_o     = state_q;
  assign frozen_o    = (state_q == FROZEN);

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Directed bench for rvfi_trace_buffer with DEPTH=4: vector table plus corner-case sequences.
module tb_rvfi_trace_buffer;
  import rvfi_trace_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] B     = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        enable_i, clear_i, trig_en_i, rvfi_valid, out_ready_i;
  logic [1:0]  mode_i;
  logic [31:0] trig_pc_i, rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata, rvfi_mem_addr;
  logic [7:0]  post_trig_i;
  logic [4:0]  rvfi_rd_addr;
  logic        out_valid_o, frozen_o;
  trace_rec_t  out_rec_o;
  logic [2:0]  count_o;
  logic [15:0] drop_cnt_o;
  logic [1:0]  state_o;

  rvfi_trace_buffer #(.DEPTH(DEPTH), .TS_W(16), .POST_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i), .mode_i(mode_i),
    .trig_en_i(trig_en_i), .trig_pc_i(trig_pc_i), .post_trig_i(post_trig_i),
    .rvfi_valid(rvfi_valid), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_insn(rvfi_insn),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_addr(rvfi_mem_addr),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_rec_o(out_rec_o),
    .count_o(count_o), .drop_cnt_o(drop_cnt_o), .state_o(state_o), .frozen_o(frozen_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, clr;
    logic [1:0]  mode;
    logic        te, vld;
    logic [31:0] pc;
    logic        rdy;
    int          cnt, drop, st;
    logic [31:0] head;
    logic        trig;
  } vec_t;

  vec_t        vecs[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] ts_model = '0;
  logic [15:0] t_a, t_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic clr, input logic [1:0] mode, input logic te,
                     input logic vld, input logic [31:0] pc, input logic rdy,
                     input int cnt, input int drop, input int st, input logic [31:0] head,
                     input logic trig);
    vec_t v;
    v.en = en; v.clr = clr; v.mode = mode; v.te = te; v.vld = vld; v.pc = pc; v.rdy = rdy;
    v.cnt = cnt; v.drop = drop; v.st = st; v.head = head; v.trig = trig;
    vecs.push_back(v);
  endtask

  // The record captured on an edge carries the timestamp value from before that edge.
  task automatic tick();
    @(posedge clk);
    if (enable_i) ts_model = ts_model + 16'd1;
    #1;
  endtask

  task automatic drive(input logic en, input logic clr, input logic [1:0] mode, input logic te,
                       input logic vld, input logic [31:0] pc, input logic rdy);
    enable_i = en; clear_i = clr; mode_i = mode; trig_en_i = te;
    rvfi_valid = vld; rvfi_pc_rdata = pc; out_ready_i = rdy;
    rvfi_insn = pc ^ 32'h0000_0013; rvfi_rd_addr = pc[6:2];
    rvfi_rd_wdata = ~pc; rvfi_mem_addr = pc + 32'h100;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    trig_pc_i = B + 32'h10;
    post_trig_i = 8'd2;
    drive(0, 0, 2'b00, 0, 0, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset count", 32'(count_o), 0);
    check("reset valid", 32'(out_valid_o), 0);
    check("reset state", 32'(state_o), 0);
    check("reset drop", 32'(drop_cnt_o), 0);
    check("reset frozen", 32'(frozen_o), 0);
    check("reset rec pc", out_rec_o.pc, 0);
    @(negedge clk);
    rst_i = 1'b0;

    // STREAM: fill, overflow, simultaneous push/pop at full, drain.
    add(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 6; k++)
      add(1, 0, 2'b00, 0, 1, B + 4 * k, 0, (k < 4) ? k + 1 : 4, (k < 4) ? 0 : k - 3, 1, B, 0);
    add(1, 0, 2'b00, 0, 1, B + 32'h18, 1, 4, 2, 1, B + 4, 0);
    add(1, 0, 2'b00, 0, 0, 0, 1, 3, 2, 1, B + 8, 0);
    add(1, 0, 2'b00, 0, 0, 0, 1, 2, 2, 1, B + 12, 0);
    add(1, 0, 2'b00, 0, 0, 0, 1, 1, 2, 1, B + 24, 0);
    add(1, 0, 2'b00, 0, 0, 0, 1, 0, 2, 1, 0, 0);
    add(1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // STOP: freezes on the fourth capture, later retirements ignored.
    for (int k = 0; k < 6; k++)
      add(1, 0, 2'b01, 0, 1, B + 4 * k, 0, (k < 4) ? k + 1 : 4, 0, (k < 3) ? 1 : 3, B, 0);
    add(1, 0, 2'b01, 0, 0, 0, 1, 3, 0, 3, B + 4, 0);
    add(1, 0, 2'b01, 0, 0, 0, 1, 2, 0, 3, B + 8, 0);
    add(1, 0, 2'b01, 0, 0, 0, 1, 1, 0, 3, B + 12, 0);
    add(1, 0, 2'b01, 0, 0, 0, 1, 0, 0, 3, 0, 0);
    add(0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // RING with trigger at B+0x10, two post-trigger records.
    add(1, 0, 2'b10, 1, 1, B,       0, 1, 0, 1, B, 0);
    add(1, 0, 2'b10, 1, 1, B + 4,   0, 2, 0, 1, B, 0);
    add(1, 0, 2'b10, 1, 1, B + 8,   0, 3, 0, 1, B, 0);
    add(1, 0, 2'b10, 1, 1, B + 12,  0, 4, 0, 1, B, 0);
    add(1, 0, 2'b10, 1, 1, B + 16,  0, 4, 1, 2, B + 4, 0);
    add(1, 0, 2'b10, 1, 1, B + 20,  0, 4, 2, 2, B + 8, 0);
    add(1, 0, 2'b10, 1, 1, B + 24,  0, 4, 3, 3, B + 12, 0);
    add(1, 0, 2'b10, 1, 1, B + 28,  0, 4, 3, 3, B + 12, 0);
    add(1, 0, 2'b10, 1, 1, B + 32,  0, 4, 3, 3, B + 12, 0);
    add(1, 0, 2'b10, 1, 0, 0, 1, 3, 3, 3, B + 16, 1);
    add(1, 0, 2'b10, 1, 0, 0, 1, 2, 3, 3, B + 20, 0);
    add(1, 0, 2'b10, 1, 0, 0, 1, 1, 3, 3, B + 24, 0);
    add(1, 0, 2'b10, 1, 0, 0, 1, 0, 3, 3, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].mode, vecs[i].te, vecs[i].vld, vecs[i].pc, vecs[i].rdy);
      tick();
      check($sformatf("v%0d count", i), 32'(count_o), vecs[i].cnt);
      check($sformatf("v%0d drop", i), 32'(drop_cnt_o), vecs[i].drop);
      check($sformatf("v%0d state", i), 32'(state_o), vecs[i].st);
      check($sformatf("v%0d frozen", i), 32'(frozen_o), (vecs[i].st == 3) ? 1 : 0);
      check($sformatf("v%0d valid", i), 32'(out_valid_o), (vecs[i].cnt != 0) ? 1 : 0);
      if (vecs[i].cnt != 0) begin
        check($sformatf("v%0d head pc", i), out_rec_o.pc, vecs[i].head);
        check($sformatf("v%0d head trig", i), 32'(out_rec_o.trig), 32'(vecs[i].trig));
      end
    end

    // Clear beats a coincident trigger-matching capture.
    drive(1, 1, 2'b00, 1, 1, B + 16, 0);
    tick();
    check("clr count", 32'(count_o), 0);
    check("clr drop", 32'(drop_cnt_o), 0);
    check("clr state", 32'(state_o), 1);
    t_a = ts_model;
    drive(1, 0, 2'b00, 1, 1, B, 0);
    tick();
    check("post-clr state", 32'(state_o), 1);
    check("post-clr head pc", out_rec_o.pc, B);
    check("post-clr head trig", 32'(out_rec_o.trig), 0);
    check("post-clr head ts", 32'(out_rec_o.ts), 32'(t_a));
    check("post-clr head wdata", out_rec_o.rd_wdata, ~B);
    t_b = ts_model;
    drive(1, 0, 2'b00, 1, 1, B + 16, 0);
    tick();
    check("stream trig state", 32'(state_o), 2);
    check("stream trig count", 32'(count_o), 2);
    drive(1, 0, 2'b00, 1, 0, 0, 1);
    tick();
    check("trig rec pc", out_rec_o.pc, B + 16);
    check("trig rec flag", 32'(out_rec_o.trig), 1);
    check("trig rec ts", 32'(out_rec_o.ts), 32'(t_b));
    check("trig rec maddr", out_rec_o.mem_addr, B + 32'h110);

    // Zero post-trigger count freezes right after the trigger record.
    drive(1, 1, 2'b00, 1, 0, 0, 0);
    tick();
    post_trig_i = 8'd0;
    drive(1, 0, 2'b00, 1, 1, B + 16, 0);
    tick();
    check("post0 state", 32'(state_o), 3);
    check("post0 count", 32'(count_o), 1);
    check("post0 trig", 32'(out_rec_o.trig), 1);
    drive(1, 0, 2'b00, 1, 1, B + 20, 0);
    tick();
    check("post0 ignored", 32'(count_o), 1);

    // Asynchronous reset between edges while capturing.
    drive(1, 1, 2'b00, 0, 0, 0, 0);
    tick();
    drive(1, 0, 2'b00, 0, 1, B, 0);
    tick();
    drive(1, 0, 2'b00, 0, 1, B + 4, 0);
    tick();
    check("pre-rst count", 32'(count_o), 2);
    drive(1, 0, 2'b00, 0, 1, B + 8, 0);
    #2 rst_i = 1'b1;
    #1;
    check("async rst valid", 32'(out_valid_o), 0);
    check("async rst count", 32'(count_o), 0);
    check("async rst state", 32'(state_o), 0);
    check("async rst frozen", 32'(frozen_o), 0);
    check("async rst rec", out_rec_o.pc, 0);
    @(negedge clk);
    rst_i = 1'b0;
    ts_model = '0;
    drive(0, 0, 2'b00, 0, 0, 0, 0);
    tick();
    check("after rst state", 32'(state_o), 0);
    drive(1, 0, 2'b00, 0, 0, 0, 0);
    tick();
    check("rearm state", 32'(state_o), 1);
    drive(1, 0, 2'b00, 0, 1, B + 32'h40, 0);
    tick();
    check("rearm ts", 32'(out_rec_o.ts), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
